// File: rtl/multicycle_ctrl_fsm_pkg.sv
// multicycle_pkg
// Shared definitions for the multicycle processor control FSM: state
// encodings, instruction op codes, datapath mux-select constants and the
// packed bundle of control strobes produced by the output decoder.
// Optional feature macro used by the files that import this package:
//   MULTICYCLE_MEM_WAIT_EN - memory handshake (mem_ready) stalls FETCH/MEMRD/MEMWR.
package multicycle_pkg;

  localparam int STATE_BITS = 4;

  // Codes 11..15 are unused and recover to S_FETCH.
  typedef enum logic [STATE_BITS-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  // instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // ALU source A select
  localparam logic [1:0] SRCA_REG    = 2'd0;
  localparam logic [1:0] SRCA_PC     = 2'd1;
  localparam logic [1:0] SRCA_ALUOUT = 2'd2;

  // ALU source B select
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'd0;
  localparam logic [1:0] RES_DATA      = 2'd1;
  localparam logic [1:0] RES_ALURESULT = 2'd2;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       illegal;
    logic       alu_op;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_out_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if
// Bundle between the control FSM and the datapath.
//   op, funct        : instruction fields (instr[27:26], instr[25:20])
//   mem_ready        : memory handshake, only with MULTICYCLE_MEM_WAIT_EN
//   ir_write..illegal: control strobes
//   alu_op, adr_src, alu_src_a, alu_src_b, result_src: mux selects
// master = control FSM, slave = datapath.
interface multicycle_ctrl_fsm_if;

  logic [1:0] op;
  logic [5:0] funct;
`ifdef MULTICYCLE_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       ir_write;
  logic       next_pc;
  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic       alu_op;
  logic       adr_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       illegal;

  modport master (
    input  op, funct,
`ifdef MULTICYCLE_MEM_WAIT_EN
    input  mem_ready,
`endif
    output ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src,
           alu_src_a, alu_src_b, result_src, illegal
  );

  modport slave (
    output op, funct,
`ifdef MULTICYCLE_MEM_WAIT_EN
    output mem_ready,
`endif
    input  ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src,
           alu_src_a, alu_src_b, result_src, illegal
  );

endinterface

// File: rtl/multicycle_ctrl_fsm_out_dec.sv
// multicycle_ctrl_out_dec
// Purely combinational Moore output decode: registered state -> control
// strobes and mux selects.
//   state : current FSM state (in)
//   ctrl  : decoded control bundle (out)
// Unused state codes decode to all-zero so a corrupted state register
// cannot issue a write while it recovers.
module multicycle_ctrl_out_dec
  import multicycle_pkg::*;
(
  input  state_t    state,
  output ctrl_out_t ctrl
);

  // Everything defaults to 0; each state only lists what it drives.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.next_pc    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALURESULT;
      end
      S_MEMADR: begin
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.reg_w      = 1'b1;
        ctrl.result_src = RES_DATA;
      end
      S_MEMWR: begin
        ctrl.mem_w      = 1'b1;
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_EXECUTER: begin
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = 1'b1;
      end
      S_ALUWB: begin
        ctrl.reg_w      = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      S_BRANCH: begin
        ctrl.branch     = 1'b1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALURESULT;
      end
      S_UNKNOWN: begin
        ctrl.illegal    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Main control state machine of the multicycle processor. Steps the shared
// datapath through fetch/decode/execute/memory/writeback, one step per clock.
//   clk     : system clock, rising edge
//   reset   : asynchronous reset, active low
//   bus     : multicycle_ctrl_fsm_if.master (instruction fields in, strobes out)
//   state_o : current state for debug
// Optional: MULTICYCLE_MEM_WAIT_EN adds bus.mem_ready; FETCH, MEMRD and MEMWR
// then hold until memory reports ready.
module multicycle_ctrl_fsm
  import multicycle_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_ctrl_fsm_if.master  bus,
  output logic [STATE_W-1:0]     state_o
);

  state_t    state_q;
  state_t    state_d;
  ctrl_out_t ctrl;
  logic      mem_rdy;
  logic      unused_funct;

  // Only the immediate bit and the load/store bit steer the sequence.
  assign unused_funct = ^bus.funct[4:1];

`ifdef MULTICYCLE_MEM_WAIT_EN
  assign mem_rdy = bus.mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // State register; reset lands in FETCH so the first released edge fetches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; op/funct come from the IR, which is stable from DECODE on.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = bus.funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = bus.funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  multicycle_ctrl_out_dec u_out_dec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Strobes are masked while reset is held: the state already reads FETCH,
  // but nothing may be written until reset is released.
  assign bus.ir_write   = ctrl.ir_write & reset;
  assign bus.next_pc    = ctrl.next_pc  & reset;
  assign bus.reg_w      = ctrl.reg_w    & reset;
  assign bus.mem_w      = ctrl.mem_w    & reset;
  assign bus.branch     = ctrl.branch   & reset;
  assign bus.illegal    = ctrl.illegal  & reset;
  assign bus.alu_op     = ctrl.alu_op;
  assign bus.adr_src    = ctrl.adr_src;
  assign bus.alu_src_a  = ctrl.alu_src_a;
  assign bus.alu_src_b  = ctrl.alu_src_b;
  assign bus.result_src = ctrl.result_src;

  assign state_o = STATE_W'(state_q);

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multicycle processor.
- Sequences the shared datapath (PC, IR, data/ALUOut flops, ALU, register file, unified memory) through fetch, decode, execute, memory and writeback steps, one step per clock.
- Emits the enable and mux-select strobes that the datapath flops and muxes consume.
- Sits inside the control unit, next to the ALU/cond decoder; it does not evaluate condition flags.

Parameters:
- STATE_W, 4, width of the state register (11 states used).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- op  in  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal.
- funct  in  6  instr[25:20]: bit5 = immediate, bit0 = L/S.
- mem_ready  in  1  memory handshake; present only with MEM_WAIT_EN.
- ir_write  out  1  instruction register load enable.
- next_pc  out  1  PC update request (PCWrite before cond/branch gating).
- reg_w  out  1  register-file write request.
- mem_w  out  1  memory write request.
- branch  out  1  branch-state indicator.
- alu_op  out  1  0 = add; 1 = decode funct.
- adr_src  out  1  0 = PC, 1 = Result.
- alu_src_a  out  2  0 = RD1 reg, 1 = PC, 2 = ALUOut.
- alu_src_b  out  2  0 = RD2 reg, 1 = ExtImm, 2 = constant 4.
- result_src  out  2  0 = ALUOut, 1 = Data, 2 = ALUResult.
- illegal  out  1  one-cycle pulse in the UNKNOWN state.
- state_o  out  STATE_W  current state, for debug.

Behaviour:
- Moore machine: outputs are a pure function of the registered state. No input-to-output combinational path.
- Reset (reset = 0) forces state = FETCH immediately (asynchronous). While reset is low, ir_write, next_pc, reg_w, mem_w, branch and illegal are forced to 0; selects take FETCH values.
- Release of reset: the first rising edge with reset = 1 executes FETCH. Reset mid-instruction abandons the instruction with no partial write.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, UNKNOWN=10. Codes 11–15 go to FETCH next cycle with all strobes 0.
- Outputs per state (unlisted strobes = 0, unlisted selects = 0):
  - FETCH: ir_write=1, next_pc=1, adr_src=0, alu_src_a=1, alu_src_b=2, result_src=2, alu_op=0.
  - DECODE: alu_src_a=1, alu_src_b=2, result_src=2.
  - MEMADR: alu_src_a=0, alu_src_b=1, alu_op=0.
  - MEMRD: adr_src=1, result_src=0.
  - MEMWB: reg_w=1, result_src=1.
  - MEMWR: mem_w=1, adr_src=1, result_src=0.
  - EXECUTER: alu_src_b=0, alu_op=1.
  - EXECUTEI: alu_src_b=1, alu_op=1.
  - ALUWB: reg_w=1, result_src=0.
  - BRANCH: branch=1, alu_src_b=1, result_src=2.
  - UNKNOWN: illegal=1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, selected by op (sampled on the DECODE edge; IR is stable by then):
    - op=01 -> MEMADR.
    - op=00 with funct[5]=1 -> EXECUTEI.
    - op=00 with funct[5]=0 -> EXECUTER.
    - op=10 -> BRANCH.
    - op=11 -> UNKNOWN.
  - MEMADR: funct[0]=1 -> MEMRD; funct[0]=0 -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - UNKNOWN -> FETCH.
- Latency in cycles: data-processing 4, load 5, store 4, branch 3, illegal 3.

Optional Feature:
- Macro: MULTICYCLE_MEM_WAIT_EN.
- Defined:
  - mem_ready port exists.
  - FETCH, MEMRD and MEMWR hold their state and keep outputs stable while mem_ready = 0. ir_write, next_pc and mem_w stay asserted throughout.
  - They advance on the first edge with mem_ready = 1.
  - Reset overrides any wait.
- Undefined: port absent; memory is treated as always ready (single-cycle memory).

Decomposition:
- Package multicycle_pkg:
  - state localparams/enum;
  - op codes OP_DP=2'b00, OP_MEM=2'b01, OP_BR=2'b10;
  - select constants SRCA_*, SRCB_*, RES_*.
- Sub-module multicycle_ctrl_out_dec: combinational state -> output decode.
- State register and next-state logic stay in the top module.

Test Plan:
- Reset low mid-MEMRD, then high -> state_o=0 immediately and all strobes 0; first edge after release gives ir_write=1, next_pc=1.
- op=00, funct=6'b101000 (ADD imm) -> states 0,1,7,8,0; reg_w=1 only in cycle 4; alu_src_b=1 in cycle 3.
- op=01, funct=6'b011001 (LDR) -> states 0,1,2,3,4,0; result_src=1 with reg_w=1 in MEMWB.
- op=01, funct=6'b011000 (STR) -> states 0,1,2,5,0; mem_w=1 for exactly one cycle, adr_src=1.
- op=10 then op=11 -> states 0,1,9,0 with branch=1 one cycle; then 0,1,10,0 with illegal one cycle; reg_w and mem_w never asserted.
- MEM_WAIT_EN defined, mem_ready low for 3 cycles in MEMRD -> state holds 4 cycles total, adr_src=1 stable, then MEMWB.
